// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared widths, burst limit and FSM state encoding for the pixel streamer
package pixel_pkg;
    localparam int PIX_ADDR_W    = 10;
    localparam int PIX_DATA_W    = 16;
    localparam int PIX_COUNT_MAX = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } pix_state_e;
endpackage

// File: rtl/pixel_skid_fifo.sv
// rtl/pixel_skid_fifo.sv - two-entry output FIFO; head entry stays put until popped
module pixel_skid_fifo #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic [WIDTH-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [1:0]       occupancy
);
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       occ;
    logic             pop;

    assign out_tvalid = (occ != 2'd0);
    assign out_tdata  = head;
    assign occupancy  = occ;
    assign pop        = out_tvalid & out_tready;

    // The writer never pushes into a full FIFO without a simultaneous pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({in_tvalid, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= in_tdata;
                    else             tail <= in_tdata;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= in_tdata;
                    end else begin
                        head <= tail;
                        tail <= in_tdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/pixel_mem_streamer.sv
// rtl/pixel_mem_streamer.sv - burst reader from pixel memory port B into a ready/valid pixel stream
module pixel_mem_streamer
    import pixel_pkg::*;
#(
    parameter int ADDR_W = PIX_ADDR_W,
    parameter int DATA_W = PIX_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic              busy,
    output logic              done
);
    pix_state_e        state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W:0]   remaining;
    logic              inflight;
    logic              inflight_last;
    logic [1:0]        fifo_occ;
    logic [1:0]        occ_after_pop;
    logic [DATA_W:0]   fifo_out;
    logic              pop;
    logic              issue;
    logic              last_issue;

    // Occupancy is taken net of this cycle's output transfer so a continuously
    // ready consumer sees one pixel per cycle without overflowing two entries.
    assign pop           = pix_valid & pix_ready;
    assign occ_after_pop = fifo_occ - {1'b0, pop};
    assign issue         = (state == ST_RUN) && ((occ_after_pop + {1'b0, inflight}) < 2'd2);
    assign last_issue    = issue && (remaining == (ADDR_W+1)'(1));

    assign mem_wren = 1'b0;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_FINISH);
    assign pix_data = fifo_out[DATA_W-1:0];
    assign pix_last = pix_valid & fifo_out[DATA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            addr_cnt      <= '0;
            remaining     <= '0;
            mem_addr      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= last_issue;
            if (issue) begin
                mem_addr  <= addr_cnt;
                addr_cnt  <= addr_cnt + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_cnt  <= base_addr;
                        remaining <= count;
                        state     <= (count == '0) ? ST_FINISH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last_issue) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pop && pix_last) state <= ST_FINISH;
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    pixel_skid_fifo #(
        .WIDTH(DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_tdata  ({inflight_last, mem_q}),
        .in_tvalid (inflight),
        .out_tdata (fifo_out),
        .out_tvalid(pix_valid),
        .out_tready(pix_ready),
        .occupancy (fifo_occ)
    );
endmodule

// File: tb/tb_pixel_mem_streamer.sv
// tb/tb_pixel_mem_streamer.sv - randomized and directed bench with a queue-based burst model
module tb_pixel_mem_streamer;
    import pixel_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] count = '0;
    logic [9:0]  mem_addr;
    logic        mem_wren;
    logic [15:0] mem_q;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_last;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:1023];
    assign mem_q = mem[mem_addr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int stall_until = 0;

    // model state, written only by the compare process
    int  exp_d[$];
    bit  exp_l[$];
    int  iss_q[$];
    int  log_d[$];
    bit  log_l[$];
    int  log_c[$];
    bit  m_busy = 0;
    bit  m_done = 0;
    bit  nxt_done;
    bit  rst_prev = 0;
    bit  hold = 0;
    int  hold_d = 0;
    bit  hold_l = 0;
    int  prev_addr = 0;
    int  acc_cyc = 0;
    int  done_cyc = 0;
    int  done_seen = 0;
    int  busy_cnt = 0;

    pixel_mem_streamer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .count    (count),
        .mem_addr (mem_addr),
        .mem_wren (mem_wren),
        .mem_q    (mem_q),
        .pix_data (pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_last (pix_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (cyc < stall_until) pix_ready = 1'b0;
        else begin
            case (rdy_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = cyc[0];
                default: pix_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Compare process: checks this cycle, then advances the model to the next edge.
    always @(negedge clk) begin
        check("mem_wren", int'(mem_wren), 0);
        check("busy", int'(busy), int'(m_busy));
        check("done", int'(done), int'(m_done));
        if (done) begin
            done_seen++;
            done_cyc = cyc;
            check("pixels_left_at_done", exp_d.size(), 0);
        end
        if (busy) busy_cnt++;
        if (rst_prev) begin
            check("reset_mem_addr", int'(mem_addr), 0);
            check("reset_pix_valid", int'(pix_valid), 0);
            check("reset_pix_last", int'(pix_last), 0);
        end else if (int'(mem_addr) != prev_addr) begin
            if (iss_q.size() > 0) begin
                check("mem_addr", int'(mem_addr), iss_q[0]);
                void'(iss_q.pop_front());
            end else begin
                check("mem_addr_spurious", int'(mem_addr), prev_addr);
            end
        end
        if (hold && !rst_prev) begin
            check("stall_valid", int'(pix_valid), 1);
            check("stall_data", int'(pix_data), hold_d);
            check("stall_last", int'(pix_last), int'(hold_l));
        end
        if (pix_valid) begin
            if (exp_d.size() > 0) begin
                check("pix_data", int'(pix_data), exp_d[0]);
                check("pix_last", int'(pix_last), int'(exp_l[0]));
            end else begin
                check("pix_valid_spurious", int'(pix_valid), 0);
            end
        end
        hold      = pix_valid && !pix_ready;
        hold_d    = int'(pix_data);
        hold_l    = pix_last;
        prev_addr = int'(mem_addr);
        nxt_done  = 0;
        if (reset) begin
            exp_d.delete();
            exp_l.delete();
            iss_q.delete();
            m_busy = 0;
            hold   = 0;
        end else begin
            if (pix_valid && pix_ready) begin
                log_d.push_back(int'(pix_data));
                log_l.push_back(pix_last);
                log_c.push_back(cyc);
                if (exp_d.size() > 0) begin
                    if (exp_l[0]) nxt_done = 1;
                    void'(exp_d.pop_front());
                    void'(exp_l.pop_front());
                end
            end
            if (m_done) m_busy = 0;
            else if (!m_busy && start) begin
                m_busy  = 1;
                acc_cyc = cyc + 1;
                for (int i = 0; i < int'(count); i++) begin
                    int a;
                    a = (int'(base_addr) + i) % 1024;
                    exp_d.push_back(int'(mem[a]));
                    exp_l.push_back(i == int'(count) - 1);
                    // a first address equal to the held mem_addr produces no visible change
                    if (!(i == 0 && a == int'(mem_addr))) iss_q.push_back(a);
                end
                if (count == '0) nxt_done = 1;
            end
        end
        m_done   = nxt_done;
        rst_prev = reset;
    end

    task automatic do_start(input int b, input int n);
        @(posedge clk); #1;
        base_addr = 10'(b);
        count     = 11'(n);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k;
        k = 0;
        while (done_seen == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_timeout", int'(done_seen != d0), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // identity memory: pixel value equals its address
    task automatic check_seq(input string name, input int lb, input int b, input int n);
        check({name, "_len"}, log_d.size() - lb, n);
        if (log_d.size() >= lb + n) begin
            for (int i = 0; i < n; i++) begin
                check({name, "_data"}, log_d[lb + i], (b + i) % 1024);
                check({name, "_last"}, int'(log_l[lb + i]), int'(i == n - 1));
            end
        end
    endtask

    initial begin
        int lb, d0, bc, k, a0, b, n;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // four pixels from address 0 with an always-ready consumer
        rdy_mode = 0;
        lb = log_d.size(); d0 = done_seen;
        do_start(0, 4);
        wait_done(d0, 50);
        check_seq("basic", lb, 0, 4);
        if (log_d.size() >= lb + 4) begin
            check("first_valid_latency", log_c[lb], acc_cyc + 2);
            for (int i = 1; i < 4; i++) check("back_to_back", log_c[lb + i], log_c[lb] + i);
            check("done_after_last", done_cyc, log_c[lb + 3] + 1);
        end

        // address wrap
        lb = log_d.size(); d0 = done_seen;
        do_start(1022, 4);
        wait_done(d0, 50);
        check_seq("wrap", lb, 1022, 4);
        if (log_d.size() >= lb + 4) begin
            check("wrap_lit2", log_d[lb + 2], 0);
            check("wrap_lit3", log_d[lb + 3], 1);
        end

        // toggling ready plus a five-cycle stall
        rdy_mode = 1;
        lb = log_d.size(); d0 = done_seen;
        do_start(0, 8);
        repeat (4) @(posedge clk);
        #1 stall_until = cyc + 5;
        wait_done(d0, 100);
        check_seq("stall", lb, 0, 8);

        // zero-length burst
        rdy_mode = 0;
        lb = log_d.size(); d0 = done_seen; bc = busy_cnt; a0 = int'(mem_addr);
        do_start(300, 0);
        wait_done(d0, 20);
        check("zero_pixels", log_d.size() - lb, 0);
        check("zero_mem_addr", int'(mem_addr), a0);
        check("zero_busy_cycles", busy_cnt - bc, 1);

        // restart request in mid-burst is ignored
        rdy_mode = 2;
        lb = log_d.size(); d0 = done_seen;
        do_start(100, 16);
        repeat (3) @(posedge clk);
        do_start(200, 3);
        wait_done(d0, 200);
        repeat (5) @(posedge clk);
        check("one_done", done_seen - d0, 1);
        check_seq("restart_ignored", lb, 100, 16);

        // abort after the third pixel; reset also beats a coincident start
        rdy_mode = 0;
        lb = log_d.size(); d0 = done_seen;
        do_start(0, 10);
        k = 0;
        while (log_d.size() < lb + 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("third_pixel_timeout", int'(log_d.size() >= lb + 3), 1);
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1; base_addr = 10'd7; count = 11'd3;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_mem_addr", int'(mem_addr), 0);
        check("abort_pix_valid", int'(pix_valid), 0);
        check("abort_pix_last", int'(pix_last), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        lb = log_d.size();
        repeat (8) @(negedge clk);
        check("abort_no_pixels", log_d.size() - lb, 0);
        check("abort_no_done", done_seen - d0, 0);
        lb = log_d.size(); d0 = done_seen;
        do_start(5, 2);
        wait_done(d0, 50);
        check_seq("after_abort", lb, 5, 2);

        // randomized bursts over random memory contents
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
            rdy_mode = $urandom_range(0, 2);
            b = $urandom_range(0, 1023);
            n = (r == 7) ? PIX_COUNT_MAX : $urandom_range(0, 40);
            d0 = done_seen;
            lb = log_d.size();
            do_start(b, n);
            if (n >= 20 && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 5)) @(posedge clk);
                do_start($urandom_range(0, 1023), $urandom_range(0, 40));
            end
            if (r % 6 == 5 && n > 4) begin
                repeat ($urandom_range(2, 12)) @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk); #1 reset = 1'b0;
                repeat (3) @(posedge clk);
            end else begin
                wait_done(d0, n * 8 + 50);
                check("rand_len", log_d.size() - lb, n);
            end
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
